// File: rtl/cpu_clk_switch_ctrl_pkg.sv
// Shared state encoding, per-state output drive and default timing constants
// for the CPU clock-source sequencer.
package cpu_clk_pkg;

   localparam int DEF_HOLD_CYCLES   = 16;
   localparam int DEF_LOCK_STABLE   = 64;
   localparam int DEF_LOCK_TIMEOUT  = 65535;
   localparam int DEF_SETTLE_CYCLES = 16;
   localparam int DEF_CNT_W         = 16;

   typedef enum logic [3:0] {
      HOLD_SYS   = 4'd0,
      RUN_SYS    = 4'd1,
      PRE_WIZ    = 4'd2,
      WAIT_LOCK  = 4'd3,
      SWITCH     = 4'd4,
      SETTLE_WIZ = 4'd5,
      RUN_WIZ    = 4'd6,
      PRE_SYS    = 4'd7,
      FALLBACK   = 4'd8
   } clk_state_t;

   typedef struct packed {
      logic en;
      logic wiz_reset;
      logic cpu_reset;
      logic busy;
   } drv_t;

   // A zero-length interval still costs one cycle.
   function automatic int eff_cycles(input int p);
      return (p < 1) ? 1 : p;
   endfunction

   // Output levels for a state; registered from the next state so each
   // output lands on the same edge as the state change that causes it.
   function automatic drv_t state_drv(input clk_state_t s);
      drv_t d;
      d = '{en: 1'b0, wiz_reset: 1'b1, cpu_reset: 1'b1, busy: 1'b1};
      case (s)
         RUN_SYS:    d = '{en: 1'b0, wiz_reset: 1'b1, cpu_reset: 1'b0, busy: 1'b0};
         PRE_WIZ:    d = '{en: 1'b0, wiz_reset: 1'b0, cpu_reset: 1'b1, busy: 1'b1};
         WAIT_LOCK:  d = '{en: 1'b0, wiz_reset: 1'b0, cpu_reset: 1'b1, busy: 1'b1};
         SWITCH:     d = '{en: 1'b0, wiz_reset: 1'b0, cpu_reset: 1'b1, busy: 1'b1};
         SETTLE_WIZ: d = '{en: 1'b1, wiz_reset: 1'b0, cpu_reset: 1'b1, busy: 1'b1};
         RUN_WIZ:    d = '{en: 1'b1, wiz_reset: 1'b0, cpu_reset: 1'b0, busy: 1'b0};
         PRE_SYS:    d = '{en: 1'b1, wiz_reset: 1'b0, cpu_reset: 1'b1, busy: 1'b1};
         default:    d = '{en: 1'b0, wiz_reset: 1'b1, cpu_reset: 1'b1, busy: 1'b1};
      endcase
      return d;
   endfunction

endpackage

// File: rtl/cpu_clk_switch_ctrl_if.sv
// Control/status bundle between the clock-switch register block (master)
// and the sequencer (slave).
interface cpu_clk_switch_ctrl_if;
   logic wiz_req;
   logic clk_wiz_locked;
   logic clk_wiz_enable;
   logic clk_wiz_reset;
   logic cpu_reset;
   logic busy;
   logic lock_fail;

   modport master (
      output wiz_req,
      output clk_wiz_locked,
      input  clk_wiz_enable,
      input  clk_wiz_reset,
      input  cpu_reset,
      input  busy,
      input  lock_fail
   );

   modport slave (
      input  wiz_req,
      input  clk_wiz_locked,
      output clk_wiz_enable,
      output clk_wiz_reset,
      output cpu_reset,
      output busy,
      output lock_fail
   );
endinterface

// File: rtl/cpu_clk_switch_ctrl_sync_2ff.sv
// Two-flop synchroniser for a single level signal, cleared to 0 by reset.
// Latency: 2 cycles. Backpressure: none.
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/cpu_clk_switch_ctrl.sv
// Sequencer for the CPU clock mux: holds the core in reset around every source change.
// Latency: outputs registered; lock decisions use the 2-cycle synchronised lock.
// Backpressure: none; wiz_req is a level, honoured only in WAIT_LOCK / RUN_* states.
module cpu_clk_switch_ctrl
   import cpu_clk_pkg::*;
#(
   parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
   parameter int LOCK_STABLE   = DEF_LOCK_STABLE,
   parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int CNT_W         = DEF_CNT_W
)(
   input  logic                 sys_clock,
   input  logic                 reset,
   cpu_clk_switch_ctrl_if.slave ctl
);

   localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(eff_cycles(HOLD_CYCLES) - 1);
   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(eff_cycles(SETTLE_CYCLES) - 1);
   localparam logic [CNT_W-1:0] TMO_LD    = CNT_W'(eff_cycles(LOCK_TIMEOUT) - 1);
   localparam logic [CNT_W-1:0] STABLE_N  = CNT_W'(eff_cycles(LOCK_STABLE));
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   clk_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] stab, stab_nxt;
   logic             lk;
   logic             req_q;
   logic             fail_set;
   logic             lock_fail_q, lock_fail_nxt;
   drv_t             drv_q, drv_nxt;

   sync_2ff u_lock_sync (
      .clk   (sys_clock),
      .reset (reset),
      .d     (ctl.clk_wiz_locked),
      .q     (lk)
   );

   always_comb begin
      state_nxt = state;
      cnt_nxt   = (cnt == '0) ? cnt : cnt - ONE;
      stab_nxt  = '0;
      fail_set  = 1'b0;

      case (state)
         HOLD_SYS: begin
            if (cnt == '0) state_nxt = RUN_SYS;
         end
         RUN_SYS: begin
            if (ctl.wiz_req && !lock_fail_q) begin
               state_nxt = PRE_WIZ;
               cnt_nxt   = HOLD_LD;
            end
         end
         PRE_WIZ: begin
            if (cnt == '0) begin
               state_nxt = WAIT_LOCK;
               cnt_nxt   = TMO_LD;
            end
         end
         WAIT_LOCK: begin
            // cnt doubles as the lock timeout; stab counts consecutive lock cycles
            if (lk) stab_nxt = (stab == CNT_MAX) ? stab : stab + ONE;
            if (!ctl.wiz_req) begin
               state_nxt = HOLD_SYS;
               cnt_nxt   = SETTLE_LD;
            end else if (stab_nxt >= STABLE_N) begin
               state_nxt = SWITCH;
            end else if (cnt == '0) begin
               state_nxt = HOLD_SYS;
               cnt_nxt   = SETTLE_LD;
               fail_set  = 1'b1;
            end
         end
         SWITCH: begin
            state_nxt = SETTLE_WIZ;
            cnt_nxt   = SETTLE_LD;
         end
         SETTLE_WIZ: begin
            if (!lk) begin
               state_nxt = FALLBACK;
               fail_set  = 1'b1;
            end else if (cnt == '0) begin
               state_nxt = RUN_WIZ;
            end
         end
         RUN_WIZ: begin
            // lock loss outranks a simultaneous request to leave
            if (!lk) begin
               state_nxt = FALLBACK;
               fail_set  = 1'b1;
            end else if (!ctl.wiz_req) begin
               state_nxt = PRE_SYS;
               cnt_nxt   = HOLD_LD;
            end
         end
         PRE_SYS: begin
            if (cnt == '0) begin
               state_nxt = HOLD_SYS;
               cnt_nxt   = SETTLE_LD;
            end
         end
         FALLBACK: begin
            state_nxt = HOLD_SYS;
            cnt_nxt   = SETTLE_LD;
         end
         default: begin
            state_nxt = HOLD_SYS;
            cnt_nxt   = SETTLE_LD;
         end
      endcase

      // a new failure beats a same-cycle clear from a falling request
      if (fail_set)
         lock_fail_nxt = 1'b1;
      else if (req_q && !ctl.wiz_req)
         lock_fail_nxt = 1'b0;
      else
         lock_fail_nxt = lock_fail_q;

      drv_nxt = state_drv(state_nxt);
   end

   always_ff @(posedge sys_clock) begin
      if (reset) begin
         state       <= HOLD_SYS;
         cnt         <= SETTLE_LD;
         stab        <= '0;
         req_q       <= 1'b0;
         lock_fail_q <= 1'b0;
         drv_q       <= state_drv(HOLD_SYS);
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         stab        <= stab_nxt;
         req_q       <= ctl.wiz_req;
         lock_fail_q <= lock_fail_nxt;
         drv_q       <= drv_nxt;
      end
   end

   assign ctl.clk_wiz_enable = drv_q.en;
   assign ctl.clk_wiz_reset  = drv_q.wiz_reset;
   assign ctl.cpu_reset      = drv_q.cpu_reset;
   assign ctl.busy           = drv_q.busy;
   assign ctl.lock_fail      = lock_fail_q;

endmodule

// File: tb/tb_cpu_clk_switch_ctrl.sv
// Directed bench: stimulus queues the expected output-change events (cycle + value),
// a negedge monitor pops one per observed change of {en, wiz_reset, cpu_reset, busy, lock_fail}.
module tb_cpu_clk_switch_ctrl;

   typedef struct {
      int         cyc;
      logic [4:0] v;
      string      nm;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   bit   done = 1'b0;
   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   logic [4:0] outs;
   logic [4:0] prev = 'x;

   cpu_clk_switch_ctrl_if bus ();

   cpu_clk_switch_ctrl dut (
      .sys_clock (clk),
      .reset     (rst),
      .ctl       (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign outs = {bus.clk_wiz_enable, bus.clk_wiz_reset, bus.cpu_reset, bus.busy, bus.lock_fail};

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic exp_at(input int c, input logic [4:0] v, input string nm);
      exp_t e;
      e.cyc = c;
      e.v   = v;
      e.nm  = nm;
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin : mon
      logic [4:0] cur;
      exp_t e;
      cur = outs;
      if (cyc != 0) begin
         if (cur !== prev) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_change cyc=%0d got=%b", cyc, cur);
            end else begin
               e = exp_q.pop_front();
               if (e.cyc != cyc || e.v !== cur) begin
                  errors++;
                  $display("FAIL %s got cyc=%0d val=%b expected cyc=%0d val=%b",
                           e.nm, cyc, cur, e.cyc, e.v);
               end
            end
            if (^prev !== 1'bx && prev[4] != cur[4]) begin
               checks++;
               if (cur[2] !== 1'b1) begin
                  errors++;
                  $display("FAIL en_while_cpu_running cyc=%0d got cpu_reset=%b required 1", cyc, cur[2]);
               end
            end
         end else if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
            checks++;
            errors++;
            e = exp_q.pop_front();
            $display("FAIL %s missed: no change by cyc=%0d, expected val=%b at cyc=%0d",
                     e.nm, cyc, e.v, e.cyc);
         end
         if (done) begin
            checks++;
            if (exp_q.size() != 0) begin
               errors++;
               $display("FAIL leftover_events got=%0d required=0", exp_q.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
         end
      end
      prev = cur;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      rst = 1'b1;
      bus.wiz_req = 1'b0;
      bus.clk_wiz_locked = 1'b0;
      exp_at(1, 5'b01110, "reset_vals");
      tick(3);

      // 1: release reset, 16 cycles of held core then RUN_SYS
      rst = 1'b0;
      t = cyc;
      exp_at(t + 16, 5'b01000, "run_sys");
      tick(20);

      // 2: request clk_wiz, lock arrives 100 cycles later
      t = cyc;
      bus.wiz_req = 1'b1;
      exp_at(t + 1, 5'b00110, "pre_wiz");
      tick(100);
      t = cyc;
      bus.clk_wiz_locked = 1'b1;
      exp_at(t + 67, 5'b10110, "en_rise");
      exp_at(t + 83, 5'b10000, "run_wiz");
      tick(90);

      // 4: lock loss in RUN_WIZ, no retry while wiz_req stays high
      t = cyc;
      bus.clk_wiz_locked = 1'b0;
      exp_at(t + 3, 5'b01111, "fallback");
      exp_at(t + 20, 5'b01001, "run_sys_fail");
      tick(40);

      // clear flag with 1->0, then re-request with a solid lock
      t = cyc;
      bus.wiz_req = 1'b0;
      exp_at(t + 1, 5'b01000, "fail_clr");
      tick(2);
      t = cyc;
      bus.wiz_req = 1'b1;
      bus.clk_wiz_locked = 1'b1;
      exp_at(t + 1, 5'b00110, "pre_wiz2");
      exp_at(t + 82, 5'b10110, "settle2");
      exp_at(t + 98, 5'b10000, "run_wiz2");
      tick(105);

      // 5: orderly return to sys_clock
      t = cyc;
      bus.wiz_req = 1'b0;
      exp_at(t + 1, 5'b10110, "pre_sys");
      exp_at(t + 17, 5'b01110, "en_fall");
      exp_at(t + 33, 5'b01000, "run_sys3");
      tick(40);

      // 3: lock toggling every 40 cycles never qualifies; timeout after 65535
      t = cyc;
      bus.wiz_req = 1'b1;
      bus.clk_wiz_locked = 1'b1;
      exp_at(t + 1, 5'b00110, "pre_wiz3");
      exp_at(t + 17 + 65535, 5'b01111, "timeout");
      exp_at(t + 17 + 65535 + 16, 5'b01001, "run_sys_timeout");
      for (int k = 0; k < 1640; k++) begin
         tick(40);
         bus.clk_wiz_locked = ~bus.clk_wiz_locked;
      end
      bus.clk_wiz_locked = 1'b0;
      tick(50);
      t = cyc;
      bus.wiz_req = 1'b0;
      exp_at(t + 1, 5'b01000, "fail_clr2");
      tick(2);
      t = cyc;
      bus.wiz_req = 1'b1;
      exp_at(t + 1, 5'b00110, "pre_wiz4");
      tick(30);

      // 6a: reset pulse while in WAIT_LOCK
      rst = 1'b1;
      t = cyc;
      exp_at(t + 1, 5'b01110, "rst_in_wait");
      tick(2);
      rst = 1'b0;
      bus.clk_wiz_locked = 1'b1;
      t = cyc;
      exp_at(t + 16, 5'b01000, "run_sys5");
      exp_at(t + 17, 5'b00110, "pre_wiz5");
      exp_at(t + 98, 5'b10110, "settle5");
      tick(105);

      // 6b: reset pulse while in SETTLE_WIZ
      rst = 1'b1;
      t = cyc;
      exp_at(t + 1, 5'b01110, "rst_in_settle");
      tick(2);
      rst = 1'b0;
      t = cyc;
      exp_at(t + 16, 5'b01000, "run_sys6");
      exp_at(t + 17, 5'b00110, "pre_wiz6");
      exp_at(t + 98, 5'b10110, "settle6");
      exp_at(t + 114, 5'b10000, "run_wiz6");
      tick(120);

      // lock loss and wiz_req=0 seen on the same edge: loss wins
      t = cyc;
      bus.clk_wiz_locked = 1'b0;
      exp_at(t + 3, 5'b01111, "loss_wins");
      exp_at(t + 20, 5'b01001, "run_sys_loss");
      tick(2);
      bus.wiz_req = 1'b0;
      tick(30);

      done = 1'b1;
   end

endmodule
